// File: rtl/array_deserializer_if.sv
// Handshake bundle for array_deserializer: element stream in, assembled array out.
// The slave modport is the deserializer's view; master is the surrounding logic.
interface array_deserializer_if #(
  parameter int N = 2,
  parameter int W = 1
);
  localparam int FILL_W = $clog2(N);

  logic              in_valid;
  logic              in_ready;
  logic [W-1:0]      in_data;
  logic              o_valid;
  logic              o_ready;
  logic [W-1:0]      o_arr [N-1:0];
  logic [N*W-1:0]    o_packed;
  logic [FILL_W-1:0] o_fill;

  modport master (
    output in_valid, in_data, o_ready,
    input  in_ready, o_valid, o_arr, o_packed, o_fill
  );

  modport slave (
    input  in_valid, in_data, o_ready,
    output in_ready, o_valid, o_arr, o_packed, o_fill
  );
endinterface

// File: rtl/array_deserializer.sv
// Collects N W-bit elements into an array; one fill buffer plus one output
// register, so the next array assembles while the previous one is held.
module array_deserializer #(
  parameter int N = 2,
  parameter int W = 1
) (
  input logic                 clk,
  input logic                 rst,
  input logic                 flush,
  array_deserializer_if.slave bus
);
  localparam int                FILL_W = $clog2(N);
  localparam logic [FILL_W-1:0] LAST   = FILL_W'(N - 1);

  logic [FILL_W-1:0] fill_cnt;
  logic [W-1:0]      fill [N-2:0];
  logic [W-1:0]      arr_q [N-1:0];
  logic              o_valid_q;
  logic [N*W-1:0]    packed_w;

  logic at_last;
  logic accept;
  logic drain;
  logic final_accept;

  assign at_last      = (fill_cnt == LAST);
  // Only the last element needs a free output slot; earlier ones never stall.
  assign bus.in_ready = !(at_last && o_valid_q && !bus.o_ready);
  assign accept       = bus.in_valid && bus.in_ready;
  assign drain        = o_valid_q && bus.o_ready;
  assign final_accept = accept && at_last;

  always_ff @(posedge clk) begin
    if (rst) begin
      fill_cnt  <= '0;
      o_valid_q <= 1'b0;
      for (int k = 0; k < N - 1; k++) fill[k] <= '0;
      for (int k = 0; k < N; k++) arr_q[k] <= '0;
    end else if (flush) begin
      fill_cnt  <= '0;
      o_valid_q <= 1'b0;
    end else if (final_accept) begin
      for (int k = 0; k < N - 1; k++) arr_q[k] <= fill[k];
      arr_q[N-1] <= bus.in_data;
      fill_cnt   <= '0;
      o_valid_q  <= 1'b1;
    end else begin
      if (accept) begin
        for (int k = 0; k < N - 1; k++) begin
          if (fill_cnt == FILL_W'(k)) fill[k] <= bus.in_data;
        end
        fill_cnt <= fill_cnt + FILL_W'(1);
      end
      if (drain) o_valid_q <= 1'b0;
    end
  end

  always_comb begin
    packed_w = '0;
    for (int k = 0; k < N; k++) packed_w[k*W +: W] = arr_q[k];
  end

  assign bus.o_valid  = o_valid_q;
  assign bus.o_arr    = arr_q;
  assign bus.o_packed = packed_w;
  assign bus.o_fill   = fill_cnt;
endmodule

// File: tb/tb_array_deserializer.sv
// Bench for array_deserializer: directed plan steps then random traffic on
// an N=2/W=1 instance and an N=3/W=4 instance, against a queue-free array model.
module tb_array_deserializer;
  logic clk = 1'b0;
  logic rst2, rst3, flush2, flush3;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  array_deserializer_if #(.N(2), .W(1)) b2 ();
  array_deserializer_if #(.N(3), .W(4)) b3 ();

  array_deserializer #(.N(2), .W(1)) dut2 (.clk(clk), .rst(rst2), .flush(flush2), .bus(b2));
  array_deserializer #(.N(3), .W(4)) dut3 (.clk(clk), .rst(rst3), .flush(flush3), .bus(b3));

  // Reference model: element count, fill contents, output slot, per instance.
  int m_n    [2] = '{2, 3};
  int m_w    [2] = '{1, 4};
  int m_mask [2] = '{1, 15};
  int m_cnt  [2];
  bit m_valid[2];
  int m_fill [2][3];
  int m_arr  [2][3];

  task automatic chk(input string tag, input int id, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s inst=%0d observed=%0h expected=%0h", tag, id, obs, exp);
    end
  endtask

  task automatic model_step(input int id, input bit iv, input int d, input bit ordy,
                            input bit fl, input bit rs);
    int n;
    bit rdy, acc, drn;
    n = m_n[id];
    if (rs) begin
      m_cnt[id] = 0;
      m_valid[id] = 1'b0;
      for (int k = 0; k < 3; k++) begin
        m_fill[id][k] = 0;
        m_arr[id][k] = 0;
      end
    end else if (fl) begin
      m_cnt[id] = 0;
      m_valid[id] = 1'b0;
    end else begin
      rdy = !(m_cnt[id] == n - 1 && m_valid[id] && !ordy);
      acc = iv && rdy;
      drn = m_valid[id] && ordy;
      if (acc && m_cnt[id] == n - 1) begin
        for (int k = 0; k < n - 1; k++) m_arr[id][k] = m_fill[id][k];
        m_arr[id][n-1] = d;
        m_valid[id] = 1'b1;
        m_cnt[id] = 0;
      end else begin
        if (acc) begin
          m_fill[id][m_cnt[id]] = d;
          m_cnt[id] = m_cnt[id] + 1;
        end
        if (drn) m_valid[id] = 1'b0;
      end
    end
  endtask

  // One clock of stimulus on instance id (other instance idles), with checks.
  task automatic step(input int id, input bit iv, input int d_in, input bit ordy,
                      input bit fl, input bit rs);
    int d;
    int n;
    bit rdy_exp;
    logic [31:0] obs;
    logic [31:0] exp_p;
    d = d_in & m_mask[id];
    n = m_n[id];
    b2.in_valid = 1'b0; b2.o_ready = 1'b0; rst2 = 1'b0; flush2 = 1'b0;
    b3.in_valid = 1'b0; b3.o_ready = 1'b0; rst3 = 1'b0; flush3 = 1'b0;
    if (id == 0) begin
      b2.in_valid = iv; b2.in_data = 1'(d); b2.o_ready = ordy; flush2 = fl; rst2 = rs;
    end else begin
      b3.in_valid = iv; b3.in_data = 4'(d); b3.o_ready = ordy; flush3 = fl; rst3 = rs;
    end
    #1;
    rdy_exp = !(m_cnt[id] == n - 1 && m_valid[id] && !ordy);
    obs = (id == 0) ? 32'(b2.in_ready) : 32'(b3.in_ready);
    if (!rs) chk("in_ready", id, obs, 32'(rdy_exp));
    model_step(id, iv, d, ordy, fl, rs);
    @(posedge clk);
    @(negedge clk);
    exp_p = '0;
    for (int k = 0; k < n; k++) exp_p = exp_p | (32'(m_arr[id][k]) << (k * m_w[id]));
    if (id == 0) begin
      chk("o_valid", id, 32'(b2.o_valid), 32'(m_valid[id]));
      chk("o_fill", id, 32'(b2.o_fill), 32'(m_cnt[id]));
      chk("o_packed", id, 32'(b2.o_packed), exp_p);
      chk("o_arr0", id, 32'(b2.o_arr[0]), 32'(m_arr[id][0]));
      chk("o_arr1", id, 32'(b2.o_arr[1]), 32'(m_arr[id][1]));
    end else begin
      chk("o_valid", id, 32'(b3.o_valid), 32'(m_valid[id]));
      chk("o_fill", id, 32'(b3.o_fill), 32'(m_cnt[id]));
      chk("o_packed", id, 32'(b3.o_packed), exp_p);
      chk("o_arr0", id, 32'(b3.o_arr[0]), 32'(m_arr[id][0]));
      chk("o_arr1", id, 32'(b3.o_arr[1]), 32'(m_arr[id][1]));
      chk("o_arr2", id, 32'(b3.o_arr[2]), 32'(m_arr[id][2]));
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time budget");
    $fatal(1, "timeout");
  end

  initial begin
    b2.in_valid = 1'b0; b2.in_data = '0; b2.o_ready = 1'b0;
    b3.in_valid = 1'b0; b3.in_data = '0; b3.o_ready = 1'b0;
    rst2 = 1'b1; rst3 = 1'b1; flush2 = 1'b0; flush3 = 1'b0;
    @(negedge clk);

    // Reset, N=2
    step(0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 1);
    chk("rst_packed", 0, 32'(b2.o_packed), 32'h0);
    chk("rst_in_ready", 0, 32'(b2.in_ready), 32'h1);

    // Basic fill with o_ready=1
    step(0, 1, 1, 1, 0, 0);
    step(0, 1, 0, 1, 0, 0);
    chk("basic_packed", 0, 32'(b2.o_packed), 32'h1);
    step(0, 0, 0, 1, 0, 0);
    chk("basic_drained", 0, 32'(b2.o_valid), 32'h0);

    // Backpressure: 1,1,0,1 with o_ready low, then one ready cycle
    step(0, 1, 1, 0, 0, 0);
    step(0, 1, 1, 0, 0, 0);
    chk("bp_packed11", 0, 32'(b2.o_packed), 32'h3);
    step(0, 1, 0, 0, 0, 0);
    step(0, 1, 1, 0, 0, 0);
    chk("bp_stalled_fill", 0, 32'(b2.o_fill), 32'h1);
    step(0, 1, 1, 1, 0, 0);
    chk("bp_packed10", 0, 32'(b2.o_packed), 32'h2);
    step(0, 0, 0, 1, 0, 0);

    // Simultaneous drain and completion
    step(0, 1, 1, 0, 0, 0);
    step(0, 1, 1, 0, 0, 0);
    step(0, 1, 0, 0, 0, 0);
    step(0, 1, 1, 1, 0, 0);
    chk("nobubble_valid", 0, 32'(b2.o_valid), 32'h1);
    chk("nobubble_packed", 0, 32'(b2.o_packed), 32'h2);
    step(0, 0, 0, 1, 0, 0);

    // Flush with a partial fill and a pending output
    step(0, 1, 1, 0, 0, 0);
    step(0, 1, 0, 0, 0, 0);
    step(0, 1, 1, 0, 0, 0);
    step(0, 1, 0, 1, 1, 0);
    chk("flush_keeps_arr", 0, 32'(b2.o_packed), 32'h1);
    // Same again with reset
    step(0, 1, 1, 0, 0, 0);
    step(0, 1, 1, 0, 0, 0);
    step(0, 1, 1, 0, 0, 0);
    step(0, 1, 0, 1, 0, 1);
    chk("rst_clears_arr", 0, 32'(b2.o_packed), 32'h0);

    // N=3, W=4
    step(1, 0, 0, 0, 0, 1);
    step(1, 0, 0, 0, 0, 1);
    step(1, 1, 'hA, 1, 0, 0);
    step(1, 1, 'h5, 1, 0, 0);
    step(1, 1, 'hF, 1, 0, 0);
    chk("n3_packed", 1, 32'(b3.o_packed), 32'hF5A);

    // Random traffic on both instances
    for (int i = 0; i < 400; i++) begin
      int id;
      id = (i < 200) ? 0 : 1;
      step(id, 1'($urandom_range(3) != 0), int'($urandom_range(15)),
           1'($urandom_range(2) != 0), 1'($urandom_range(31) == 0),
           1'($urandom_range(63) == 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/array_deserializer.md
Name: array_deserializer

Overview:
- Sequential stage directly upstream of the array-assignment logic.
- Collects a stream of W-bit elements under a valid/ready handshake into an unpacked array `o_arr[N-1:0]`.
- Presents the array, plus its packed equivalent, to the downstream consumer under a second valid/ready handshake.
- Double-buffered: one fill buffer plus one output register, so a new array can be assembled while the previous one is held.

Parameters:
- N, 2, number of elements per output array (N >= 2)
- W, 1, width of each element in bits (W >= 1)

Ports:
- clk  input  1  sole clock, all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- flush  input  1  synchronous discard of partial fill and of the pending output
- in_valid  input  1  upstream element valid
- in_ready  output  1  stage can accept an element this cycle
- in_data  input  W  element value
- o_valid  output  1  o_arr/o_packed hold a complete array
- o_ready  input  1  downstream accepts the array this cycle
- o_arr  output  unpacked [N-1:0] of [W-1:0]  assembled array, registered
- o_packed  output  N*W  packed view: o_arr[k] at bits [k*W +: W]
- o_fill  output  clog2(N)  number of elements currently in the fill buffer

Behaviour:
- Reset (rst=1 at clock edge):
  - fill_cnt=0, fill buffer all zero.
  - o_valid=0, o_arr all elements zero, o_packed=0.
  - rst has priority over flush and over both handshakes.
- Accept: an element is accepted when in_valid && in_ready.
  - The k-th accepted element of an array (k=0 first) goes to index k.
  - Element 0 lands in o_arr[0]; the last element lands in o_arr[N-1].
- in_ready = !(fill_cnt==N-1 && o_valid && !o_ready).
  - This is combinational from o_ready.
  - in_ready is 1 at all other times, including immediately after reset.
- Output drain: the output is drained when o_valid && o_ready.
- Non-final accept (fill_cnt<N-1): store into fill[fill_cnt], fill_cnt+=1. The output register is untouched.
- Final accept (fill_cnt==N-1), only possible when the output slot is free (o_valid==0 or drained this cycle):
  - Next cycle, o_arr = fill[0..N-2] plus in_data at index N-1.
  - o_valid=1, fill_cnt=0.
  - Latency: o_valid rises one cycle after the final element's accept edge.
- Drain with no final accept in the same cycle: o_valid->0 next cycle. o_arr retains its last value and is not cleared.
- Simultaneous drain and final accept: o_valid stays 1 with no bubble; o_arr takes the new array next cycle.
- o_arr and o_valid are stable while o_valid && !o_ready; downstream may sample at any time.
- flush=1 (rst=0):
  - fill_cnt=0, o_valid=0 next cycle.
  - Any accept or drain in the same cycle is discarded.
  - Fill buffer and o_arr contents are left unchanged; only the counters and valid are cleared.
- fill_cnt wraps from N-1 to 0 only on a final accept. It never exceeds N-1.
- o_fill = fill_cnt.
- in_data while !in_valid is ignored. o_ready while !o_valid has no effect.
- No combinational path from in_data to o_arr/o_packed.

Test Plan:
- Reset, N=2, W=1: hold rst 2 cycles -> o_valid=0, o_arr='{0,0}, o_packed=2'b00, in_ready=1, o_fill=0.
- Basic fill, o_ready=1: accept 1 then 0 on consecutive cycles.
  - Cycle after the 2nd accept: o_valid=1, o_arr[0]=1, o_arr[1]=0, o_packed=2'b01.
  - Next cycle: o_valid=0.
- Backpressure, o_ready=0: stream 1,1,0,1 with in_valid held high.
  - After 2 accepts: o_valid=1, o_packed=2'b11.
  - 3rd element (0) accepted, o_fill=1.
  - in_ready=0 while 4th element pending.
  - Raise o_ready for one cycle -> 4th accepted that cycle; next cycle o_valid=1, o_packed=2'b10.
- Simultaneous drain and completion: with o_valid=1 holding 2'b11, o_ready=1 on the same cycle as the final accept of 0,1 -> o_valid stays 1, o_packed=2'b10 next cycle, no bubble.
- Flush and mid-operation reset:
  - Accept one element, then pulse flush while o_valid=1 -> next cycle o_fill=0, o_valid=0.
  - Repeat with rst instead -> o_arr returns to '{0,0}.
- Parameter check, N=3, W=4: accept 4'hA, 4'h5, 4'hF -> o_arr[0]=A, o_arr[1]=5, o_arr[2]=F, o_packed=12'hF5A.
